iir_decim: RTL and testbench
============================

Name: iir_decim

Overview:
- Downstream consumer of the IIR filter output: takes the filter's 15-bit sample stream (one sample per clk, qualified by in_valid), averages non-overlapping blocks of 2^DECIM_LOG2 samples, and emits one decimated sample per block.
- Results are buffered in a small first-word-fall-through (FWFT) FIFO with a valid/ready output handshake, so a slower sink can apply backpressure without stalling the filter.

Parameters:
- DATA_W, 15, sample width; two's-complement signed on input and output.
- DECIM_LOG2, 2, log2 of decimation factor N; N = 4 by default; legal range 0..4.
- FIFO_AW, 2, log2 of FIFO depth; depth = 4 entries by default.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low
- x_in  input  DATA_W  filter output sample (signed)
- in_valid  input  1  x_in valid this cycle; tie high for a free-running filter
- y_out  output  DATA_W  decimated sample at FIFO head; 0 when out_valid=0
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  sink accepts y_out this cycle
- level  output  FIFO_AW+1  current FIFO occupancy
- ovf  output  1  sticky overflow flag; a result was dropped

Behaviour:
- Reset: on a clk edge with rst=0, the block clears the accumulator, phase counter, FIFO pointers, level and ovf. out_valid and y_out become 0. Reset during a partial block or with a non-empty FIFO discards everything.
- Accumulator: signed, DATA_W+DECIM_LOG2 bits, so it cannot overflow. Input is sign-extended before addition.
- Phase counter: 0..N-1. It advances only on in_valid=1 and holds during in_valid=0 gaps.
- On in_valid with phase < N-1: acc <= acc + x_in; phase <= phase + 1.
- On in_valid with phase = N-1:
  - sum = acc + x_in
  - result = sum >>> DECIM_LOG2 (arithmetic shift, i.e. floor)
  - result is pushed to the FIFO on the same edge; acc <= 0; phase <= 0.
- Result width: the shifted value always fits DATA_W; the block takes the low DATA_W bits.
- DECIM_LOG2 = 0: pass-through. Every valid sample is pushed unchanged.
- Latency: out_valid rises the cycle after the clk edge that captured the N-th sample of a block (when the FIFO was empty).
- FIFO is FWFT: y_out = mem[rd_ptr] while out_valid=1.
- Pop: on a clk edge with out_valid & out_ready. out_ready is ignored when the FIFO is empty.
- Push with FIFO not full: accepted.
- Push with FIFO full:
  - simultaneous pop: accepted; level unchanged, ovf unchanged.
  - no pop: result is dropped, FIFO unchanged, ovf <= 1.
- ovf clears only on reset.
- Pointers: FIFO_AW-bit, natural wrap. level is a separate counter (push only: +1; pop only: -1; both or neither: hold).
- Sink-side rule: out_valid never deasserts without a pop; y_out is stable while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: IIR_DECIM_ROUND_EN
- Defined: result = (sum + 2^(DECIM_LOG2-1)) >>> DECIM_LOG2, i.e. round-half-up. The rounding constant is 0 when DECIM_LOG2 = 0. The adder is widened by one bit so it cannot overflow.
- Undefined: plain arithmetic-shift truncation (floor).

Decomposition:
- Shared package/include iir_pkg: IIR_DATA_W = 15 (shared with the filter), the default decimation and FIFO widths, and a signed-sample typedef/width macro.
- One sub-module, iir_sync_fifo: parameterised DATA_W/FIFO_AW, FWFT, with push/pop/full/empty/level.
- iir_decim contains the accumulator, phase counter, ovf logic and the FIFO instance.

Test Plan:
1. Reset, out_ready=1, continuous samples 1000, 4, 1, 5:
   - sum 1010 → y_out = 252 (253 with ROUND_EN).
   - out_valid high for exactly one cycle, the cycle after the 4th sample; level returns to 0.
2. Samples -1, -1, -1, -2:
   - sum -5 → y_out = -2 truncated (-1 with ROUND_EN). Checks sign extension and floor behaviour.
3. Samples 11, 233, 543, 23 with 2 idle in_valid=0 cycles between each:
   - y_out = 202; phase holds across gaps; exactly one output.
4. out_ready=0, five blocks of constant 8:
   - level reaches 4, y_out = 8, 5th result dropped, ovf = 1.
   - Then out_ready=1: four pops in 4 consecutive cycles; level goes 4→0; ovf stays 1.
5. FIFO full (level 4), out_ready=1 on the same edge a new block completes:
   - push accepted, level stays 4, ovf stays 0, output order preserved.
6. Two samples (100, 100), then rst=0 for one cycle, then samples 1, 2, 3, 4:
   - a single output y_out = 2 (3 with ROUND_EN); no residue from the pre-reset samples.

Source files
------------

// File: rtl/iir_pkg.sv
// Shared definitions for the IIR filter chain: sample width, default
// decimation/FIFO sizing and the signed sample type.
package iir_pkg;

  localparam int IIR_DATA_W     = 15;
  localparam int IIR_DECIM_LOG2 = 2;
  localparam int IIR_FIFO_AW    = 2;

  typedef logic signed [IIR_DATA_W-1:0] iir_sample_t;

endpackage

// File: rtl/iir_decim_if.sv
// Sample-in / decimated-out bus of iir_decim. The master drives samples and
// the sink ready; the slave (iir_decim) returns the FIFO head and status.
interface iir_decim_if
  import iir_pkg::*;
#(
  parameter int DATA_W  = IIR_DATA_W,
  parameter int FIFO_AW = IIR_FIFO_AW
);
  // in_valid qualifies x_in for one edge and has no back-pressure. On the
  // output side a word moves on every edge where out_valid && out_ready;
  // out_valid never drops without that transfer and y_out holds meanwhile.
  logic [DATA_W-1:0]  x_in;
  logic               in_valid;
  logic [DATA_W-1:0]  y_out;
  logic               out_valid;
  logic               out_ready;
  logic [FIFO_AW:0]   level;
  logic               ovf;

  modport master (
    output x_in, in_valid, out_ready,
    input  y_out, out_valid, level, ovf
  );

  modport slave (
    input  x_in, in_valid, out_ready,
    output y_out, out_valid, level, ovf
  );

endinterface

// File: rtl/iir_sync_fifo.sv
// First-word-fall-through synchronous FIFO; a push into a full FIFO is only
// taken when a pop happens on the same edge.
module iir_sync_fifo #(
  parameter int DATA_W  = 15,
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [DATA_W-1:0]  push_data,
  input  logic               pop,
  output logic [DATA_W-1:0]  pop_data,
  output logic               full,
  output logic               empty,
  output logic [FIFO_AW:0]   level
);

  localparam int DEPTH = 1 << FIFO_AW;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [FIFO_AW:0]   cnt;
  logic               do_push;
  logic               do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (FIFO_AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage carries no reset; the occupancy counter alone defines validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign pop_data = empty ? '0 : mem[rd_ptr];
  assign level    = cnt;

endmodule

// File: rtl/iir_decim.sv
// Block-average decimator behind the IIR filter, results buffered in a FWFT
// FIFO. Define IIR_DECIM_ROUND_EN for round-half-up instead of floor.
module iir_decim
  import iir_pkg::*;
#(
  parameter int DATA_W     = IIR_DATA_W,
  parameter int DECIM_LOG2 = IIR_DECIM_LOG2,
  parameter int FIFO_AW    = IIR_FIFO_AW
) (
  input  logic        clk,
  input  logic        rst,
  iir_decim_if.slave  bus
);

  localparam int ACC_W = DATA_W + DECIM_LOG2;
  localparam int PH_W  = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'((1 << DECIM_LOG2) - 1);

  logic signed [DATA_W-1:0] x_s;
  logic signed [ACC_W-1:0]  x_ext;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  sum;
  logic [PH_W-1:0]          phase;
  logic [DATA_W-1:0]        result;
  logic                     last;
  logic                     push;
  logic                     pop;
  logic                     full;
  logic                     empty;
  logic                     ovf;

  assign x_s   = bus.x_in;
  assign x_ext = ACC_W'(x_s);
  assign sum   = acc + x_ext;

`ifdef IIR_DECIM_ROUND_EN
  localparam int RND = (1 << DECIM_LOG2) / 2;
  logic signed [ACC_W:0] sum_w;
  // One extra bit so adding the half-LSB constant cannot wrap.
  assign sum_w  = (ACC_W+1)'(sum) + (ACC_W+1)'(RND);
  assign result = DATA_W'(sum_w >>> DECIM_LOG2);
`else
  assign result = DATA_W'(sum >>> DECIM_LOG2);
`endif

  assign last = (phase == PH_LAST);
  assign push = bus.in_valid & last;
  assign pop  = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc   <= '0;
      phase <= '0;
      ovf   <= 1'b0;
    end else begin
      if (bus.in_valid) begin
        if (last) begin
          acc   <= '0;
          phase <= '0;
        end else begin
          acc   <= sum;
          phase <= phase + 1'b1;
        end
      end
      // A full FIFO still takes the result when the sink pops on this edge.
      if (push && full && !pop) ovf <= 1'b1;
    end
  end

  iir_sync_fifo #(
    .DATA_W  (DATA_W),
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (result),
    .pop       (pop),
    .pop_data  (bus.y_out),
    .full      (full),
    .empty     (empty),
    .level     (bus.level)
  );

  assign bus.out_valid = ~empty;
  assign bus.ovf       = ovf;

endmodule

// File: tb/tb_iir_decim.sv
// Directed bench for iir_decim (N=4, depth 4); expected values follow the
// IIR_DECIM_ROUND_EN setting of the build.
module tb_iir_decim;

  localparam int W = 15;

`ifdef IIR_DECIM_ROUND_EN
  localparam int E1 = 253;
  localparam int E2 = -1;
  localparam int E3 = 203;
  localparam int E6 = 3;
`else
  localparam int E1 = 252;
  localparam int E2 = -2;
  localparam int E3 = 202;
  localparam int E6 = 2;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  iir_decim_if #(.DATA_W(W), .FIFO_AW(2)) bus ();

  iir_decim dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int n_out  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every accepted output word must match the queue head.
  always @(negedge clk) begin
    if (rst && bus.out_valid && bus.out_ready) begin
      n_out++;
      check("sb_pending", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0)
        check("sb_y_out", int'($signed(bus.y_out)), int'($signed(exp_q.pop_front())));
    end
  end

  task automatic do_reset();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic send(input int x);
    bus.x_in     = W'(x);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_block(input int v);
    for (int i = 0; i < 4; i++) send(v);
  endtask

  int base;

  initial begin
    bus.x_in      = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Reset state
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_y_out", int'(bus.y_out), 0);
    check("rst_level", int'(bus.level), 0);
    check("rst_ovf", int'(bus.ovf), 0);

    // 1: continuous 1000,4,1,5
    base = n_out;
    exp_q.push_back(W'(E1));
    send(1000); send(4); send(1);
    check("t1_early_valid", int'(bus.out_valid), 0);
    send(5);
    check("t1_valid", int'(bus.out_valid), 1);
    check("t1_y_out", int'($signed(bus.y_out)), E1);
    check("t1_level", int'(bus.level), 1);
    idle(1);
    check("t1_valid_drop", int'(bus.out_valid), 0);
    check("t1_level_end", int'(bus.level), 0);
    check("t1_count", n_out - base, 1);

    // 2: negative samples, sign extension and floor
    base = n_out;
    exp_q.push_back(W'(E2));
    send(-1); send(-1); send(-1); send(-2);
    check("t2_y_out", int'($signed(bus.y_out)), E2);
    idle(1);
    check("t2_count", n_out - base, 1);

    // 3: gaps of two idle cycles between samples
    base = n_out;
    exp_q.push_back(W'(E3));
    send(11);  idle(2);
    send(233); idle(2);
    send(543); idle(2);
    check("t3_gap_valid", int'(bus.out_valid), 0);
    send(23);
    check("t3_y_out", int'($signed(bus.y_out)), E3);
    idle(3);
    check("t3_count", n_out - base, 1);
    check("t3_q_empty", exp_q.size(), 0);

    // 4: stalled sink, five blocks of 8, fifth dropped
    bus.out_ready = 1'b0;
    for (int b = 0; b < 5; b++) begin
      if (b < 4) exp_q.push_back(W'(8));
      send_block(8);
      check($sformatf("t4_level_b%0d", b), int'(bus.level), (b < 4) ? b + 1 : 4);
      check($sformatf("t4_ovf_b%0d", b), int'(bus.ovf), (b < 4) ? 0 : 1);
    end
    check("t4_y_head", int'($signed(bus.y_out)), 8);
    base = n_out;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      idle(1);
      check($sformatf("t4_drain_level%0d", i), int'(bus.level), 3 - i);
    end
    check("t4_drain_count", n_out - base, 4);
    check("t4_ovf_sticky", int'(bus.ovf), 1);

    // 5: push into a full FIFO with a simultaneous pop
    do_reset();
    check("t5_ovf_clear", int'(bus.ovf), 0);
    bus.out_ready = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      exp_q.push_back(W'(10 * b));
      send_block(10 * b);
    end
    check("t5_full_level", int'(bus.level), 4);
    exp_q.push_back(W'(50));
    send(50); send(50); send(50);
    bus.out_ready = 1'b1;
    send(50);
    check("t5_level_hold", int'(bus.level), 4);
    check("t5_ovf", int'(bus.ovf), 0);
    idle(4);
    check("t5_level_end", int'(bus.level), 0);
    check("t5_q_empty", exp_q.size(), 0);

    // 6: reset mid-block leaves no residue
    base = n_out;
    send(100); send(100);
    do_reset();
    check("t6_level_rst", int'(bus.level), 0);
    exp_q.push_back(W'(E6));
    send(1); send(2); send(3); send(4);
    check("t6_y_out", int'($signed(bus.y_out)), E6);
    idle(3);
    check("t6_count", n_out - base, 1);
    check("t6_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
